egress_frame_scheduler: RTL

// - Per-egress-port frame scheduler between the four ingress frame queues and one tx lane of the crossbar.
// - Grants one ingress queue at a time with round-robin fairness and drains that whole frame before rearbitrating.
// - Drives tx_data/tx_ctrl for its port and enforces the inter-frame gap.
// - One instance per egress port (4 total).

---
 rtl/egress_frame_scheduler_if.sv | 13 +
 rtl/egress_frame_scheduler.sv | 92 +++++++++
 2 files changed

// File: rtl/egress_frame_scheduler_if.sv
// egress_frame_scheduler_if: ingress queue heads/pops and the tx lane of one egress port
interface egress_frame_scheduler_if #(
  parameter int P_PORTS = 4
);
  logic [P_PORTS-1:0]   req_i;
  logic [P_PORTS-1:0]   last_i;
  logic [8*P_PORTS-1:0] data_i;
  logic [P_PORTS-1:0]   rd_o;
  logic [7:0]           tx_data_o;
  logic                 tx_ctrl_o;
  modport master (output req_i, last_i, data_i, input rd_o, tx_data_o, tx_ctrl_o);
  modport slave  (input req_i, last_i, data_i, output rd_o, tx_data_o, tx_ctrl_o);
endinterface

// File: rtl/egress_frame_scheduler.sv
// egress_frame_scheduler: round-robin whole-frame scheduler for one egress tx lane with IFG and length watchdog.
// Define SCHED_STATS_EN to add the frames_o/aborts_o counters (tied to 0 otherwise).
module egress_frame_scheduler #(
  parameter int P_PORTS     = 4,
  parameter int P_IFG       = 12,
  parameter int P_MAX_BYTES = 1522,
  parameter int P_CNT_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  egress_frame_scheduler_if.slave    bus,
  output logic [$clog2(P_PORTS)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       abort_o,
  output logic [P_CNT_W-1:0]         frames_o,
  output logic [P_CNT_W-1:0]         aborts_o
);
  localparam int GW = $clog2(P_PORTS);
  localparam int CW = $clog2(P_MAX_BYTES + 1);
  localparam int IW = P_IFG > 1 ? $clog2(P_IFG) : 1;
  typedef enum logic [2:0] {IDLE, ARB, SEND, FLUSH, GAP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] gap;
  logic [GW-1:0] pick, idx;
  logic [7:0] data_g, tx_data;
  logic any_req, last_g, pop, at_max, abort_hit, tx_ctrl;
  assign any_req   = |bus.req_i;
  assign last_g    = bus.last_i[grant_o];
  assign data_g    = bus.data_i[{grant_o, 3'b000} +: 8];
  assign pop       = state == SEND || state == FLUSH;
  assign at_max    = cnt == CW'(P_MAX_BYTES - 1);
  assign abort_hit = state == SEND && !last_g && at_max;
  assign busy_o    = state != IDLE;
  assign bus.rd_o      = pop ? P_PORTS'(1) << grant_o : '0;
  assign bus.tx_data_o = tx_data;
  assign bus.tx_ctrl_o = tx_ctrl;
  // Walk from farthest to nearest so the first requester after grant_o wins.
  always_comb begin
    pick = grant_o;
    idx  = '0;
    for (int i = P_PORTS; i >= 1; i--) begin
      idx = GW'((int'(grant_o) + i) % P_PORTS);
      if (bus.req_i[idx]) pick = idx;
    end
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = any_req ? ARB : IDLE;
      ARB:     state_nxt = any_req ? SEND : IDLE;
      SEND:    state_nxt = last_g ? GAP : at_max ? FLUSH : SEND;
      FLUSH:   state_nxt = last_g ? GAP : FLUSH;
      GAP:     state_nxt = gap == '0 ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_o <= GW'(P_PORTS - 1);
      cnt     <= '0;
      gap     <= '0;
      tx_data <= '0;
      tx_ctrl <= 1'b0;
      abort_o <= 1'b0;
    end else begin
      if (state == ARB && any_req) grant_o <= pick;
      cnt     <= state == ARB ? '0 : state == SEND && cnt != CW'(P_MAX_BYTES) ? cnt + 1'b1 : cnt;
      gap     <= state == GAP ? gap - 1'b1 : IW'(P_IFG - 1);
      tx_ctrl <= state == SEND;
      if (state == SEND) tx_data <= data_g;
      abort_o <= abort_hit;
    end
  end
`ifdef SCHED_STATS_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frames_o <= '0;
      aborts_o <= '0;
    end else begin
      if (state == SEND && last_g) frames_o <= frames_o + 1'b1;
      if (abort_hit) aborts_o <= aborts_o + 1'b1;
    end
  end
`else
  assign frames_o = '0;
  assign aborts_o = '0;
`endif
endmodule
